// File: rtl/rsnn_step_scheduler.sv
// rtl/rsnn_step_scheduler.sv - time-multiplexed LIF step scheduler; optional watchdog via RSNN_DP_WATCHDOG_EN
module rsnn_step_scheduler #(
    parameter int NUM_NEURONS = 4,
    localparam int IDX_W = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_start,
    input  logic                   clear_state,
    input  logic [7:0]             feedback_scale,
    output logic [IDX_W-1:0]       ext_sel,
    input  logic [7:0]             ext_current,
    output logic                   dp_req,
    input  logic                   dp_ack,
    output logic [IDX_W-1:0]       dp_idx,
    output logic [7:0]             dp_potential,
    output logic [7:0]             dp_refrac,
    output logic [7:0]             dp_current,
    input  logic [7:0]             dp_potential_nxt,
    input  logic [7:0]             dp_refrac_nxt,
    input  logic                   dp_spike,
    output logic                   busy,
    output logic                   step_done,
`ifdef RSNN_DP_WATCHDOG_EN
    output logic                   dp_timeout_err,
`endif
    output logic [NUM_NEURONS-1:0] spike_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
    logic [7:0]             pot_q    [NUM_NEURONS];
    logic [7:0]             refrac_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] prev_spike_q;
    logic [NUM_NEURONS-1:0] shadow_q;
    logic [NUM_NEURONS-1:0] spike_vec_q;

    logic                   wr_en;
    logic                   advance;
    logic                   clr_all;
    logic                   load_vec;
    logic [IDX_W-1:0]       src_idx;
    logic [8:0]             sum;

`ifdef RSNN_DP_WATCHDOG_EN
    logic [3:0]             wd_cnt_q;
    logic                   timeout;
    logic                   timeout_err_q;
`endif

    // Recurrent current: previous-step spike of the ring predecessor adds the feedback weight, then saturate
    always_comb begin
        src_idx = (cur_idx_q == '0) ? LAST_IDX : cur_idx_q - IDX_W'(1);
        sum     = {ext_current[7], ext_current}
                + (prev_spike_q[src_idx] ? {feedback_scale[7], feedback_scale} : 9'd0);
        if (!sum[8] && sum[7]) begin
            dp_current = 8'h7F;
        end else if (sum[8] && !sum[7]) begin
            dp_current = 8'h80;
        end else begin
            dp_current = sum[7:0];
        end
    end

    assign ext_sel      = cur_idx_q;
    assign dp_idx       = cur_idx_q;
    assign dp_potential = pot_q[cur_idx_q];
    assign dp_refrac    = refrac_q[cur_idx_q];
    assign spike_vec    = spike_vec_q;

    // Next-state and control decode for the sweep FSM
    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        wr_en     = 1'b0;
        advance   = 1'b0;
        clr_all   = 1'b0;
        load_vec  = 1'b0;
        dp_req    = 1'b0;
        busy      = 1'b0;
        step_done = 1'b0;
`ifdef RSNN_DP_WATCHDOG_EN
        timeout   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (clear_state) begin
                    clr_all = 1'b1;
                end else if (step_start) begin
                    state_d   = S_ISSUE;
                    cur_idx_d = '0;
                end
            end
            S_ISSUE: begin
                dp_req = 1'b1;
                busy   = 1'b1;
                if (dp_ack) begin
                    wr_en   = 1'b1;
                    advance = 1'b1;
                end
`ifdef RSNN_DP_WATCHDOG_EN
                else if (wd_cnt_q == 4'd14) begin
                    // 15th cycle without an ack: skip this neuron, leave its state untouched
                    timeout = 1'b1;
                    advance = 1'b1;
                end
`endif
                if (advance) begin
                    if (cur_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cur_idx_d = cur_idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                step_done = 1'b1;
                load_vec  = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and sweep index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
        end
    end

    // Per-neuron potential / refractory register file with writeback on ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i]    <= 8'h00;
                refrac_q[i] <= 8'h00;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i]    <= 8'h00;
                refrac_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            pot_q[cur_idx_q]    <= dp_potential_nxt;
            refrac_q[cur_idx_q] <= dp_refrac_nxt;
        end
    end

    // Spikes collect in a shadow vector and publish atomically when DONE exits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            prev_spike_q <= '0;
            spike_vec_q  <= '0;
        end else if (clr_all) begin
            shadow_q     <= '0;
            prev_spike_q <= '0;
            spike_vec_q  <= '0;
        end else begin
            if (advance) begin
                shadow_q[cur_idx_q] <= wr_en & dp_spike;
            end
            if (load_vec) begin
                prev_spike_q <= shadow_q;
                spike_vec_q  <= shadow_q;
            end
        end
    end

`ifdef RSNN_DP_WATCHDOG_EN
    // Ack watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= 4'd0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE && !advance) begin
                wd_cnt_q <= wd_cnt_q + 4'd1;
            end else begin
                wd_cnt_q <= 4'd0;
            end
            if (clr_all) begin
                timeout_err_q <= 1'b0;
            end else if (timeout) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign dp_timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_rsnn_step_scheduler.sv
// tb/tb_rsnn_step_scheduler.sv - self-checking bench for rsnn_step_scheduler
module tb_rsnn_step_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic          step_start;
    logic          clear_state;
    logic [7:0]    feedback_scale;
    logic [IW-1:0] ext_sel;
    logic [7:0]    ext_current;
    logic          dp_req;
    logic          dp_ack;
    logic [IW-1:0] dp_idx;
    logic [7:0]    dp_potential;
    logic [7:0]    dp_refrac;
    logic [7:0]    dp_current;
    logic [7:0]    dp_potential_nxt;
    logic [7:0]    dp_refrac_nxt;
    logic          dp_spike;
    logic          busy;
    logic          step_done;
    logic [N-1:0]  spike_vec;
`ifdef RSNN_DP_WATCHDOG_EN
    logic          dp_timeout_err;
`endif

    logic [7:0]    ext_tab [N];
    assign ext_current = ext_tab[ext_sel];

    // reference model state
    logic [7:0]    m_pot [N];
    logic [7:0]    m_ref [N];
    logic [N-1:0]  m_prev;
    logic [N-1:0]  m_vec;

    // responder controls and observations
    int            g_dmax;
    int            g_del_idx;
    int            g_del_val;
    bit            g_force_spk;
    bit            g_force_pot;
    logic [N-1:0]  g_spk_pat;
    logic [7:0]    g_obs_cur [N];
    logic [7:0]    g_obs_pot [N];

    int            n_tests;
    int            n_fail;

    rsnn_step_scheduler #(.NUM_NEURONS(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .step_start       (step_start),
        .clear_state      (clear_state),
        .feedback_scale   (feedback_scale),
        .ext_sel          (ext_sel),
        .ext_current      (ext_current),
        .dp_req           (dp_req),
        .dp_ack           (dp_ack),
        .dp_idx           (dp_idx),
        .dp_potential     (dp_potential),
        .dp_refrac        (dp_refrac),
        .dp_current       (dp_current),
        .dp_potential_nxt (dp_potential_nxt),
        .dp_refrac_nxt    (dp_refrac_nxt),
        .dp_spike         (dp_spike),
        .busy             (busy),
        .step_done        (step_done),
`ifdef RSNN_DP_WATCHDOG_EN
        .dp_timeout_err   (dp_timeout_err),
`endif
        .spike_vec        (spike_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_current(input int i);
        int src;
        int e;
        int f;
        int s;
        src = (i + N - 1) % N;
        e   = $signed(ext_tab[i]);
        f   = m_prev[src] ? $signed(feedback_scale) : 0;
        s   = e + f;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s[7:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_pot[i] = 8'h00;
            m_ref[i] = 8'h00;
        end
        m_prev = '0;
        m_vec  = '0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) ext_tab[i] = 8'($urandom);
        feedback_scale = 8'($urandom);
    endtask

    // one full sweep acting as the datapath; noise injects ignored step_start/clear_state/ack
    task automatic do_step(input bit noise);
        logic [N-1:0] shadow;
        shadow     = '0;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            int d;
            if (i == g_del_idx) d = g_del_val;
            else if (g_dmax == 0) d = 0;
            else d = $urandom_range(g_dmax, 0);
            for (int k = 0; k <= d; k++) begin
                logic [IW-1:0] ei;
                ei = i[IW-1:0];
                if (k == 0) begin
                    g_obs_cur[i] = dp_current;
                    g_obs_pot[i] = dp_potential;
                end
                n_tests++;
                if (dp_req !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL issue_req idx=%0d: dp_req=%b busy=%b, required 1 1", i, dp_req, busy);
                end
                n_tests++;
                if (dp_idx !== ei || ext_sel !== ei) begin
                    n_fail++;
                    $display("FAIL issue_idx: dp_idx=%0d ext_sel=%0d, required %0d", dp_idx, ext_sel, ei);
                end
                n_tests++;
                if (dp_potential !== m_pot[i] || dp_refrac !== m_ref[i]) begin
                    n_fail++;
                    $display("FAIL issue_state idx=%0d: pot=%h refrac=%h, required %h %h",
                             i, dp_potential, dp_refrac, m_pot[i], m_ref[i]);
                end
                n_tests++;
                if (dp_current !== exp_current(i)) begin
                    n_fail++;
                    $display("FAIL issue_current idx=%0d: dp_current=%h, required %h", i, dp_current, exp_current(i));
                end
                if (noise) begin
                    step_start  = 1'($urandom);
                    clear_state = 1'($urandom);
                end
                dp_ack           = (k == d);
                dp_potential_nxt = (g_force_pot && i == 1) ? 8'h25 : 8'($urandom);
                dp_refrac_nxt    = 8'($urandom);
                dp_spike         = g_force_spk ? g_spk_pat[i] : 1'($urandom);
                @(posedge clk); #1;
                if (dp_ack) begin
                    m_pot[i]  = dp_potential_nxt;
                    m_ref[i]  = dp_refrac_nxt;
                    shadow[i] = dp_spike;
                end
            end
        end
        dp_ack = 1'($urandom);
        n_tests++;
        if (step_done !== 1'b1 || busy !== 1'b1 || dp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle: step_done=%b busy=%b dp_req=%b, required 1 1 0", step_done, busy, dp_req);
        end
        n_tests++;
        if (spike_vec !== m_vec) begin
            n_fail++;
            $display("FAIL done_hold_vec: spike_vec=%b, required %b", spike_vec, m_vec);
        end
        if (noise) begin
            step_start  = 1'b1;
            clear_state = 1'b1;
        end
        @(posedge clk); #1;
        step_start  = 1'b0;
        clear_state = 1'b0;
        dp_ack      = 1'b0;
        m_vec       = shadow;
        m_prev      = shadow;
        n_tests++;
        if (step_done !== 1'b0 || busy !== 1'b0 || dp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: step_done=%b busy=%b dp_req=%b, required 0 0 0", step_done, busy, dp_req);
        end
        n_tests++;
        if (spike_vec !== m_vec) begin
            n_fail++;
            $display("FAIL spike_vec: spike_vec=%b, required %b", spike_vec, m_vec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step_start = 1'b0;
        clear_state = 1'b0;
        dp_ack = 1'b0;
        dp_potential_nxt = 8'h00;
        dp_refrac_nxt = 8'h00;
        dp_spike = 1'b0;
        rand_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (dp_req !== 1'b0 || busy !== 1'b0 || step_done !== 1'b0 || spike_vec !== '0 || dp_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_state: dp_req=%b busy=%b step_done=%b spike_vec=%b dp_idx=%0d, required 0 0 0 0 0",
                     dp_req, busy, step_done, spike_vec, dp_idx);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_sweep();
        g_dmax = 0;
        g_force_spk = 1'b1;
        g_spk_pat = 4'b0100;
        rand_inputs();
        do_step(1'b0);
        n_tests++;
        if (spike_vec !== 4'b0100) begin
            n_fail++;
            $display("FAIL basic_spike_vec: spike_vec=%b, required 0100", spike_vec);
        end
    endtask

    task automatic test_recurrence_saturation();
        g_force_spk = 1'b1;
        g_spk_pat = 4'b0100;
        for (int i = 0; i < N; i++) ext_tab[i] = 8'h70;
        feedback_scale = 8'h20;
        do_step(1'b0);
        n_tests++;
        if (g_obs_cur[3] !== 8'h7F || g_obs_cur[1] !== 8'h70) begin
            n_fail++;
            $display("FAIL sat_pos: cur3=%h cur1=%h, required 7f 70", g_obs_cur[3], g_obs_cur[1]);
        end
        for (int i = 0; i < N; i++) ext_tab[i] = 8'h90;
        feedback_scale = 8'hE0;
        do_step(1'b0);
        n_tests++;
        if (g_obs_cur[3] !== 8'h80 || g_obs_cur[1] !== 8'h90) begin
            n_fail++;
            $display("FAIL sat_neg: cur3=%h cur1=%h, required 80 90", g_obs_cur[3], g_obs_cur[1]);
        end
        g_force_spk = 1'b0;
    endtask

    task automatic test_delayed_ack();
        rand_inputs();
        g_del_idx = 1;
        g_del_val = 3;
        g_force_pot = 1'b1;
        do_step(1'b0);
        g_del_idx = -1;
        g_force_pot = 1'b0;
        do_step(1'b0);
        n_tests++;
        if (g_obs_pot[1] !== 8'h25) begin
            n_fail++;
            $display("FAIL delayed_writeback: pot1=%h, required 25", g_obs_pot[1]);
        end
    endtask

    task automatic test_ignored_inputs();
        for (int c = 0; c < 4; c++) begin
            dp_ack = 1'b1;
            dp_potential_nxt = 8'($urandom);
            dp_refrac_nxt = 8'($urandom);
            dp_spike = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if (busy !== 1'b0 || dp_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ack: busy=%b dp_req=%b, required 0 0", busy, dp_req);
            end
        end
        dp_ack = 1'b0;
        g_dmax = 2;
        for (int s = 0; s < 4; s++) begin
            rand_inputs();
            do_step(1'b1);
        end
        g_dmax = 0;
    endtask

    task automatic test_clear();
        g_force_spk = 1'b1;
        g_spk_pat = 4'b1011;
        rand_inputs();
        do_step(1'b0);
        g_force_spk = 1'b0;
        clear_state = 1'b1;
        step_start = 1'b1;
        @(posedge clk); #1;
        clear_state = 1'b0;
        step_start = 1'b0;
        model_clear();
        n_tests++;
        if (busy !== 1'b0 || spike_vec !== '0) begin
            n_fail++;
            $display("FAIL clear_idle: busy=%b spike_vec=%b, required 0 0000", busy, spike_vec);
        end
        do_step(1'b0);
    endtask

    task automatic test_random();
        g_dmax = 3;
        for (int s = 0; s < 20; s++) begin
            rand_inputs();
            do_step(1'b1);
        end
        g_dmax = 0;
    endtask

    task automatic test_reset_mid_sweep();
        g_force_spk = 1'b1;
        g_spk_pat = 4'b1111;
        do_step(1'b0);
        g_force_spk = 1'b0;
        step_start = 1'b1;
        @(posedge clk); #1;
        step_start = 1'b0;
        dp_ack = 1'b1;
        dp_potential_nxt = 8'h5A;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dp_req !== 1'b0 || busy !== 1'b0 || spike_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_sweep: dp_req=%b busy=%b spike_vec=%b, required 0 0 0000",
                     dp_req, busy, spike_vec);
        end
        dp_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        rand_inputs();
        @(posedge clk); #1;
        do_step(1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        g_dmax = 0;
        g_del_idx = -1;
        g_del_val = 0;
        g_force_spk = 1'b0;
        g_force_pot = 1'b0;
        g_spk_pat = '0;
        test_reset();
        test_basic_sweep();
        test_recurrence_saturation();
        test_delayed_ack();
        test_ignored_inputs();
        test_clear();
        test_random();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
